// File: rtl/serial_decoder_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
// master = operand producer + result consumer, slave = arithmetic unit.
interface serial_decoder_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_decoder_adder.sv
// Bit-serial adder/subtractor, one bit per clock LSB first; each bit is
// resolved by a 3-to-8 one-hot decoder full-adder cell.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | shifting one bit per cycle through the decoder cell
// DONE  | result held on out_valid until out_ready
module serial_decoder_adder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_decoder_adder_if.slave bus,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt, sum_q;
   logic             carry, cout_q, ovf_q;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       dec;
   logic             sum_bit, carry_nxt, last_bit;

   // One-hot minterm index is {a_bit, b_bit, carry}.
   always_comb begin
      dec       = 8'b0000_0001 << {a_sr[0], b_sr[0], carry};
      sum_bit   = dec[1] | dec[2] | dec[4] | dec[7];
      carry_nxt = dec[3] | dec[5] | dec[6] | dec[7];
      res_nxt   = (res_sr >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
      last_bit  = (cnt == LAST_BIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = bus.in_valid  ? RUN  : IDLE;
         RUN:     state_nxt = last_bit      ? DONE : RUN;
         DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // sum_q is separate from the shifting result so outputs stay frozen
   // from DONE through IDLE and the whole of the next RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               carry  <= carry_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum_q  <= res_nxt;
                  cout_q <= carry_nxt;
                  ovf_q  <= carry ^ carry_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign busy          = (state == RUN);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_decoder_adder.sv
// Bench for serial_decoder_adder at WIDTH 8, 1 and 32, checked against an
// arithmetic reference model and a table of known vectors.
module tb_serial_decoder_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_decoder_adder_if #(.WIDTH(8))  if8 ();
   serial_decoder_adder_if #(.WIDTH(1))  if1 ();
   serial_decoder_adder_if #(.WIDTH(32)) if32 ();

   logic bz [3];
   logic ir [3];
   logic ov [3];
   logic co [3];
   logic of [3];
   logic [31:0] sm [3];
   logic iv [3];
   logic orr [3];
   logic [31:0] drv_a, drv_b;
   logic drv_sub;

   serial_decoder_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8),  .busy(bz[0]));
   serial_decoder_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1),  .busy(bz[1]));
   serial_decoder_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32), .busy(bz[2]));

   assign if8.in_valid  = iv[0];
   assign if8.a         = drv_a[7:0];
   assign if8.b         = drv_b[7:0];
   assign if8.sub       = drv_sub;
   assign if8.out_ready = orr[0];
   assign ir[0] = if8.in_ready;
   assign ov[0] = if8.out_valid;
   assign sm[0] = 32'(if8.sum);
   assign co[0] = if8.cout;
   assign of[0] = if8.ovf;

   assign if1.in_valid  = iv[1];
   assign if1.a         = drv_a[0:0];
   assign if1.b         = drv_b[0:0];
   assign if1.sub       = drv_sub;
   assign if1.out_ready = orr[1];
   assign ir[1] = if1.in_ready;
   assign ov[1] = if1.out_valid;
   assign sm[1] = 32'(if1.sum);
   assign co[1] = if1.cout;
   assign of[1] = if1.ovf;

   assign if32.in_valid  = iv[2];
   assign if32.a         = drv_a;
   assign if32.b         = drv_b;
   assign if32.sub       = drv_sub;
   assign if32.out_ready = orr[2];
   assign ir[2] = if32.in_ready;
   assign ov[2] = if32.out_valid;
   assign sm[2] = if32.sum;
   assign co[2] = if32.cout;
   assign of[2] = if32.ovf;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned carry/borrow and true signed range test.
   task automatic model(input int w, input longint a, input longint b, input bit s,
                        output logic [31:0] es, output logic ec, output logic eo);
      longint mask, r, sa, sb, sr, half;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      if (s) begin
         r  = a - b;
         ec = (a >= b);
      end else begin
         r  = a + b;
         ec = (r > mask);
      end
      es = 32'(r & mask);
      sa = (a >= half) ? a - (mask + 1) : a;
      sb = (b >= half) ? b - (mask + 1) : b;
      sr = s ? sa - sb : sa + sb;
      eo = (sr > half - 1) || (sr < -half);
   endtask

   task automatic run_op(input int d, input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] es, input logic ec, input logic eo,
                         input bit hold);
      int lat;
      @(negedge clk);
      drv_a = a; drv_b = b; drv_sub = s; iv[d] = 1'b1;
      chk("in_ready_idle", 64'(ir[d]), 64'd1);
      @(posedge clk); #1;
      iv[d] = 1'b0;
      drv_a = $urandom; drv_b = $urandom; drv_sub = ~s;
      chk("busy_run", 64'(bz[d]), 64'd1);
      chk("in_ready_run", 64'(ir[d]), 64'd0);
      lat = 0;
      while (!ov[d] && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(w));
      chk("sum", 64'(sm[d]), 64'(es));
      chk("cout", 64'(co[d]), 64'(ec));
      chk("ovf", 64'(of[d]), 64'(eo));
      if (!hold) begin
         @(negedge clk); orr[d] = 1'b1;
         @(posedge clk); #1; orr[d] = 1'b0;
         chk("release_valid", 64'(ov[d]), 64'd0);
         chk("release_ready", 64'(ir[d]), 64'd1);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t tbl [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] es;
      logic ec, eo;
      logic [31:0] ra, rb;
      logic rs;
      int pulses;

      tbl[0] = '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
      tbl[1] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
      tbl[2] = '{8'd127, 8'd1,   1'b0, 8'h80,  1'b0, 1'b1};
      tbl[3] = '{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0};
      tbl[4] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};

      for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; orr[d] = 1'b0; end
      drv_a = '0; drv_b = '0; drv_sub = 1'b0;
      #22;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_in_ready", 64'(ir[d]), 64'd1);
         chk("rst_out_valid", 64'(ov[d]), 64'd0);
         chk("rst_busy", 64'(bz[d]), 64'd0);
         chk("rst_sum", 64'(sm[d]), 64'd0);
         chk("rst_cout", 64'(co[d]), 64'd0);
         chk("rst_ovf", 64'(of[d]), 64'd0);
      end

      for (int i = 0; i < 5; i++)
         run_op(0, 8, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].sub,
                32'(tbl[i].sum), tbl[i].cout, tbl[i].ovf, 1'b0);

      // Backpressure: result must hold and new operands must be ignored.
      run_op(0, 8, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); drv_a = 32'h55; drv_b = 32'h22; drv_sub = 1'b0; iv[0] = 1'b1;
         @(posedge clk); #1;
         chk("bp_valid", 64'(ov[0]), 64'd1);
         chk("bp_sum", 64'(sm[0]), 64'h10);
         chk("bp_in_ready", 64'(ir[0]), 64'd0);
      end
      @(negedge clk); iv[0] = 1'b0; orr[0] = 1'b1;
      @(posedge clk); #1; orr[0] = 1'b0;
      chk("bp_release_valid", 64'(ov[0]), 64'd0);
      chk("bp_release_idle", 64'(ir[0]), 64'd1);
      @(posedge clk); #1;
      chk("bp_no_launch", 64'(bz[0]), 64'd0);

      // Asynchronous reset while bit 3 is in flight.
      @(negedge clk); drv_a = 32'hFF; drv_b = 32'h01; drv_sub = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1; iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(bz[0]), 64'd0);
      chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
      chk("mid_rst_valid", 64'(ov[0]), 64'd0);
      chk("mid_rst_sum", 64'(sm[0]), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ov[0]) pulses++;
      end
      chk("mid_rst_no_pulse", 64'(pulses), 64'd0);
      chk("mid_rst_ready_after", 64'(ir[0]), 64'd1);
      run_op(0, 8, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         ra = 32'($urandom_range(255)); rb = 32'($urandom_range(255)); rs = 1'($urandom);
         model(8, longint'(ra), longint'(rb), rs, es, ec, eo);
         run_op(0, 8, ra, rb, rs, es, ec, eo, 1'b0);
      end

      for (int v = 0; v < 8; v++) begin
         ra = 32'((v >> 2) & 1); rb = 32'((v >> 1) & 1); rs = 1'(v & 1);
         model(1, longint'(ra), longint'(rb), rs, es, ec, eo);
         run_op(1, 1, ra, rb, rs, es, ec, eo, 1'b0);
      end

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         if (i % 50 == 0) ra = 32'h8000_0000;
         if (i % 50 == 1) rb = 32'hFFFF_FFFF;
         model(32, longint'(ra), longint'(rb), rs, es, ec, eo);
         run_op(2, 32, ra, rb, rs, es, ec, eo, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_decoder_adder.md
Name: serial_decoder_adder

Overview:
- Parametrised bit-serial adder/subtractor with a valid/ready handshake on both sides.
- Each bit is resolved by a 3-to-8 one-hot decoder full-adder cell: the decoder input is {a_bit, b_bit, carry}, and sum/carry are ORs of the decoded minterms.
- Processes one bit per clock, LSB first, for a WIDTH-bit result.
- Sits between an operand producer and a result consumer as a low-area arithmetic unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, do not override.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands a, b and sub are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B; sampled on acceptance.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  final carry; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - sum = 0, cout = 0, ovf = 0; counter and shift registers cleared.
- States: IDLE, RUN, DONE (encoded with 2 bits).
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid=1: load A into the A shift register.
  - Load B into the B shift register, inverted if sub=1.
  - carry = sub, counter = 0, then go to RUN.
  - in_valid=0 keeps the block in IDLE.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle, the decoder cell takes {A[0], B[0], carry} and decodes it one-hot.
  - sum_bit = minterm 1|2|4|7; carry_next = minterm 3|5|6|7.
  - sum_bit shifts into the result MSB and the result shifts right; A and B shift right; counter increments.
  - When the counter reaches WIDTH-1, the edge that processes the MSB also moves to DONE and sets:
    - cout = carry_next;
    - ovf = carry into MSB XOR carry_next.
- Latency: if operands are accepted at edge T0, out_valid is high after edge T0+WIDTH. WIDTH=1 gives a 1-cycle RUN.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - in_ready = 0; in_valid is ignored.
  - On an edge with out_ready=1: out_valid drops and state returns to IDLE.
  - There is no same-cycle turnaround; the next operand can be accepted one cycle later at the earliest.
  - sum, cout and ovf keep their last values in IDLE until the next DONE.
- Input stability: a, b and sub only need to be stable in the accept cycle; changes during RUN have no effect.
- Unsigned result = {cout, sum} for add. Signed result is sum, with ovf flagging a result out of range.
- Reset mid-operation (rst_n low during RUN or DONE):
  - immediate return to IDLE with all outputs at reset values;
  - the partial result is discarded and out_valid never pulses.
- No illegal-state lockup: an unused state encoding goes to IDLE on the next edge.

Test Plan:
All cases use WIDTH=8 unless stated.
- Add, no carry: a=100, b=27, sub=0 -> out_valid exactly 8 cycles after acceptance; sum=127, cout=0, ovf=0.
- Unsigned carry and signed overflow:
  - a=200, b=100, add -> sum=44, cout=1, ovf=0.
  - a=127, b=1, add -> sum=128 (0x80), cout=0, ovf=1.
- Subtract:
  - a=5, b=7, sub=1 -> sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: after completing a=0x0F, b=0x01, hold out_ready=0 for 5 cycles.
  - out_valid stays 1 with sum=0x10 stable, and in_ready=0.
  - A new in_valid with different operands is ignored.
  - Raising out_ready gives IDLE next cycle.
- Reset mid-RUN: accept a=0xFF, b=0x01, then pull rst_n low asynchronously at bit 3.
  - Outputs clear immediately, and in_ready=1 after release.
  - The next operation a=3, b=4 returns sum=7.
- Width sweep: WIDTH=1 and WIDTH=32, exhaustive for 1-bit and random for 32-bit (1000 vectors).
  - Results match the reference model for sum, cout and ovf.
  - Latency equals WIDTH.
